// File: rtl/sonar_pkg.sv
// sonar_pkg: FSM state type, speed of sound and cycle-count helpers for sonar_ranger
package sonar_pkg;
   typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_e;
   localparam int SOUND_SPEED_MM_S = 343_210;
   function automatic int cyc_per_us(input int clk_freq);
      return clk_freq / 1_000_000;
   endfunction
   // Round trip: echo width covers twice the distance.
   function automatic int cyc_per_mm(input int clk_freq);
      return 2 * clk_freq / SOUND_SPEED_MM_S;
   endfunction
endpackage

// File: rtl/sonar_echo_sync.sv
// sonar_echo_sync: 2-flop synchronizer for the echo pin with rise/fall pulses
//   echo_i   raw asynchronous echo pin
//   echo_s_o synchronized echo level
//   rise_o   one-cycle pulse on a synchronized 0->1 transition
//   fall_o   one-cycle pulse on a synchronized 1->0 transition
module sonar_echo_sync (
   input  logic clk,
   input  logic rst,
   input  logic echo_i,
   output logic echo_s_o,
   output logic rise_o,
   output logic fall_o
);
   logic s1_q, s2_q, prev_q;
   always_ff @(posedge clk)
      if (rst) {s1_q, s2_q, prev_q} <= '0;
      else     {s1_q, s2_q, prev_q} <= {echo_i, s1_q, s2_q};
   assign echo_s_o = s2_q;
   assign rise_o   = s2_q & ~prev_q;
   assign fall_o   = ~s2_q & prev_q;
endmodule

// File: rtl/sonar_ranger.sv
// sonar_ranger: ultrasonic ranger controller (trigger, echo timing, mm conversion)
//   start      request one measurement (ignored while busy)
//   echo       asynchronous sensor echo pin
//   trig       sensor trigger pin
//   busy       high while not IDLE
//   dist_mm    last measured distance, dist_valid pulses on update
//   timeout    one-cycle pulse when no complete echo arrives in time
module sonar_ranger
   import sonar_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 38_000,
   parameter int HOLDOFF_US = 10_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        echo,
   output logic        trig,
   output logic        busy,
   output logic [15:0] dist_mm,
   output logic        dist_valid,
   output logic        timeout
);
   localparam int TRIG_CYC = cyc_per_us(CLK_FREQ) * TRIG_US;
   localparam int TMO_CYC  = cyc_per_us(CLK_FREQ) * TIMEOUT_US;
   localparam int HOLD_CYC = cyc_per_us(CLK_FREQ) * HOLDOFF_US;
   localparam int CPM      = cyc_per_mm(CLK_FREQ);
   localparam logic [31:0] TRIG_M1 = 32'(TRIG_CYC - 1);
   localparam logic [31:0] TMO_C   = 32'(TMO_CYC);
   localparam logic [31:0] HOLD_M1 = 32'(HOLD_CYC - 1);
   localparam logic [31:0] CPM_M1  = 32'(CPM - 1);
   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d, psc_q, psc_d, cnt_inc, psc_nx;
   logic [15:0] acc_q, acc_d, dist_q, dist_d, acc_nx;
   logic        trig_q, trig_d, busy_q, valid_q, valid_d, tmo_q, tmo_d;
   logic        echo_s, rise, fall, psc_wrap, tmo_hit;
   sonar_echo_sync u_sync (
      .clk(clk), .rst(rst), .echo_i(echo),
      .echo_s_o(echo_s), .rise_o(rise), .fall_o(fall)
   );
   assign cnt_inc  = cnt_q + 32'd1;
   assign tmo_hit  = cnt_inc >= TMO_C;
   assign psc_wrap = psc_q == CPM_M1;
   assign psc_nx   = psc_wrap ? '0 : psc_q + 32'd1;
   assign acc_nx   = (psc_wrap && acc_q != 16'hFFFF) ? acc_q + 16'd1 : acc_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      psc_d   = psc_q;
      acc_d   = acc_q;
      dist_d  = dist_q;
      trig_d  = trig_q;
      valid_d = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = TRIG;
            trig_d  = 1'b1;
            cnt_d   = '0;
         end
         TRIG: begin
            cnt_d = cnt_inc;
            if (cnt_q == TRIG_M1) begin
               state_d = WAIT_ECHO;
               trig_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         WAIT_ECHO: begin
            cnt_d = cnt_inc;
            if (tmo_hit) begin
               state_d = HOLDOFF;
               tmo_d   = 1'b1;
               cnt_d   = '0;
            end else if (rise) begin
               state_d = MEASURE;
               psc_d   = '0;
               acc_d   = '0;
            end
         end
         MEASURE: begin
            cnt_d = cnt_inc;
            psc_d = psc_nx;
            acc_d = acc_nx;
            // Echo fall beats a simultaneous timeout; the loaded value includes this cycle.
            if (fall) begin
               state_d = HOLDOFF;
               dist_d  = acc_nx;
               valid_d = 1'b1;
               cnt_d   = '0;
            end else if (tmo_hit) begin
               state_d = HOLDOFF;
               tmo_d   = 1'b1;
               cnt_d   = '0;
            end
         end
         HOLDOFF: begin
            cnt_d = (cnt_q < HOLD_M1) ? cnt_inc : cnt_q;
            if (cnt_q >= HOLD_M1 && !echo_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         psc_q   <= '0;
         acc_q   <= '0;
         dist_q  <= '0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         psc_q   <= psc_d;
         acc_q   <= acc_d;
         dist_q  <= dist_d;
         trig_q  <= trig_d;
         busy_q  <= state_d != IDLE;
         valid_q <= valid_d;
         tmo_q   <= tmo_d;
      end
   assign trig       = trig_q;
   assign busy       = busy_q;
   assign dist_mm    = dist_q;
   assign dist_valid = valid_q;
   assign timeout    = tmo_q;
endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: self-checking bench acting as the sensor, scaled to 2 MHz for short runs
module tb_sonar_ranger;
   localparam int CF = 2_000_000, T_US = 5, TO_US = 1000, H_US = 50;
   localparam int TRIG_CYC = (CF / 1_000_000) * T_US;
   localparam int TMO_CYC  = (CF / 1_000_000) * TO_US;
   localparam int HOLD_CYC = (CF / 1_000_000) * H_US;
   localparam int CPM      = 2 * CF / 343_210;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, echo = 1'b0;
   logic trig, busy, dist_valid, timeout;
   logic [15:0] dist_mm;
   int total = 0, bad = 0, n_valid = 0, n_tmo = 0;
   sonar_ranger #(.CLK_FREQ(CF), .TRIG_US(T_US), .TIMEOUT_US(TO_US), .HOLDOFF_US(H_US)) dut (
      .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig), .busy(busy),
      .dist_mm(dist_mm), .dist_valid(dist_valid), .timeout(timeout)
   );
   always #5 clk = ~clk;
   always @(negedge clk)
      if (!rst) begin
         if (dist_valid) n_valid++;
         if (timeout) n_tmo++;
      end
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_trig(output int w);
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (trig && w < 10000) begin
         tick();
         w++;
      end
   endtask
   task automatic echo_pulse(input int dly, input int hi, output int lat);
      repeat (dly) tick();
      echo = 1'b1;
      repeat (hi) tick();
      echo = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!dist_valid && lat < 50);
   endtask
   task automatic wait_idle(output int c);
      c = 0;
      while (busy && c < 5000) begin
         tick();
         c++;
      end
   endtask
   initial begin
      int w, lat, c, v0, t0, hi, dly, diff;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_trig", trig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dist", dist_mm, 0);
      chk("rst_valid", dist_valid, 0);
      chk("rst_tmo", timeout, 0);
      // nominal 100 mm
      wait_trig(w);
      chk("trig_width", w, TRIG_CYC);
      echo_pulse(50, 100 * CPM, lat);
      chk("nom_latency", lat, 3);
      chk("nom_dist", dist_mm, 100);
      tick();
      chk("nom_valid_1cyc", dist_valid, 0);
      wait_idle(c);
      chk("nom_holdoff", c + 1, HOLD_CYC);
      // timeout with echo held low
      v0 = n_valid;
      wait_trig(w);
      c = 0;
      while (!timeout && c < 5000) begin
         tick();
         c++;
      end
      chk("tmo_time", c, TMO_CYC);
      chk("tmo_dist_kept", dist_mm, 100);
      tick();
      chk("tmo_1cyc", timeout, 0);
      wait_idle(c);
      chk("tmo_holdoff", c + 1, HOLD_CYC);
      chk("tmo_no_valid", n_valid, v0);
      // echo stuck high from before trig falls
      t0 = n_tmo;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      echo = 1'b1;
      w = 0;
      while (trig && w < 100) begin
         tick();
         w++;
      end
      c = 0;
      while (!timeout && c < 5000) begin
         tick();
         c++;
      end
      chk("stuck_tmo_time", c, TMO_CYC);
      repeat (300) tick();
      chk("stuck_busy", busy, 1);
      echo = 1'b0;
      wait_idle(c);
      chk("stuck_release", c, 3);
      chk("stuck_no_valid", n_valid, v0);
      chk("stuck_one_tmo", n_tmo, t0 + 1);
      // start pulses during MEASURE and HOLDOFF are dropped
      v0 = n_valid;
      wait_trig(w);
      repeat (5) tick();
      echo = 1'b1;
      repeat (200) tick();
      repeat (4) begin
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (50) tick();
      end
      echo = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!dist_valid && lat < 50);
      chk("busy_dist", dist_mm, 404 / CPM);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(c);
      repeat (5) tick();
      chk("no_queue_trig", trig, 0);
      chk("no_queue_busy", busy, 0);
      chk("single_valid", n_valid, v0 + 1);
      // reset mid-MEASURE
      v0 = n_valid;
      t0 = n_tmo;
      wait_trig(w);
      repeat (5) tick();
      echo = 1'b1;
      repeat (300) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_trig", trig, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_dist", dist_mm, 0);
      repeat (20) tick();
      echo = 1'b0;
      repeat (TMO_CYC + 100) tick();
      chk("mrst_no_valid", n_valid, v0);
      chk("mrst_no_tmo", n_tmo, t0);
      // randomized back-to-back measurements
      for (int i = 0; i < 40; i++) begin
         dly = int'($urandom_range(1, 50));
         hi  = int'($urandom_range(1, 100)) * CPM + int'($urandom_range(0, CPM - 1));
         wait_trig(w);
         echo_pulse(dly, hi, lat);
         chk("rand_latency", lat, 3);
         diff = int'(dist_mm) - hi / CPM;
         chk("rand_dist_within_1", int'(diff <= 1 && diff >= -1), 1);
         wait_idle(c);
      end
      chk("rand_no_tmo", n_tmo, t0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
